// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation run controller: FSM states, status codes
// and a width helper for index ports.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } status_t;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_evt_detect.sv
// Rising-edge detector over the event channels with a lowest-index-wins
// priority encoder; the previous-level register runs in every non-reset cycle.
module sim_evt_detect
  import sim_ctrl_pkg::*;
#(
  parameter int N_CH = 3
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic [N_CH-1:0]               i_evt,
  output logic                          o_valid,
  output logic [clog2_min1(N_CH)-1:0]   o_idx
);

  localparam int CH_W = clog2_min1(N_CH);

  logic [N_CH-1:0] evt_prev_reg;
  logic [N_CH-1:0] rise_vec;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      evt_prev_reg <= '0;
    end else begin
      evt_prev_reg <= i_evt;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_rise
    assign rise_vec[gi] = i_evt[gi] & ~evt_prev_reg[gi];
  end

  // Scan from the top down so the lowest set channel is the last writer.
  always_comb begin
    o_valid = |rise_vec;
    o_idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rise_vec[i]) begin
        o_idx = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: holds the DUT in reset, watches event channels, classifies
// the first rising edge (or a timeout), drains, then reports a sticky status.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int              N_CH         = 3,
  parameter int              TIMEOUT_CYC  = 10000,
  parameter int              DRAIN_CYC    = 100,
  parameter int              RST_HOLD_CYC = 3,
  parameter logic [N_CH-1:0] FAIL_MASK    = '0,
  parameter int              CNT_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                        sysclk,
  input  logic                        rst_n,
  input  logic [N_CH-1:0]             i_evt,
  output logic                        o_dut_rst,
  output logic                        o_done,
  output logic [1:0]                  o_status,
  output logic [clog2_min1(N_CH)-1:0] o_evt_ch,
  output logic [CNT_W-1:0]            o_cycles
);

  localparam int CH_W    = clog2_min1(N_CH);
  localparam int HOLD_W  = clog2_min1(RST_HOLD_CYC + 1);
  localparam int DRAIN_W = clog2_min1(DRAIN_CYC + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD_CYC);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  state_t              state_reg, state_next;
  status_t             status_reg, status_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
  logic [CNT_W-1:0]    cycles_reg, cycles_next;
  logic [CH_W-1:0]     evt_ch_reg, evt_ch_next;
  logic                dut_rst_reg, dut_rst_next;
  logic                done_reg, done_next;

  logic                evt_valid;
  logic [CH_W-1:0]     evt_idx;

  sim_evt_detect #(
    .N_CH (N_CH)
  ) u_detect (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .i_evt   (i_evt),
    .o_valid (evt_valid),
    .o_idx   (evt_idx)
  );

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_reg     <= HOLD;
      status_reg    <= ST_RUN;
      hold_cnt_reg  <= '0;
      drain_cnt_reg <= '0;
      cycles_reg    <= '0;
      evt_ch_reg    <= '0;
      dut_rst_reg   <= 1'b1;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      status_reg    <= status_next;
      hold_cnt_reg  <= hold_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      cycles_reg    <= cycles_next;
      evt_ch_reg    <= evt_ch_next;
      dut_rst_reg   <= dut_rst_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    status_next    = status_reg;
    hold_cnt_next  = hold_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    cycles_next    = cycles_reg;
    evt_ch_next    = evt_ch_reg;
    dut_rst_next   = dut_rst_reg;
    done_next      = done_reg;

    case (state_reg)
      HOLD: begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_next   = RUN;
          dut_rst_next = 1'b0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end

      RUN: begin
        if (cycles_reg != {CNT_W{1'b1}}) begin
          cycles_next = cycles_reg + 1'b1;
        end
        // An edge in the final RUN cycle still beats the timeout.
        if (evt_valid) begin
          evt_ch_next = evt_idx;
          status_next = FAIL_MASK[evt_idx] ? ST_FAIL : ST_PASS;
          if (DRAIN_CYC == 0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = DRAIN;
          end
        end else if (cycles_reg == TMO_LAST) begin
          status_next = ST_TMO;
          state_next  = DONE;
          done_next   = 1'b1;
        end
      end

      DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  assign o_dut_rst = dut_rst_reg;
  assign o_done    = done_reg;
  assign o_status  = status_reg;
  assign o_evt_ch  = evt_ch_reg;
  assign o_cycles  = cycles_reg;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: directed and random event waveforms, each scored
// edge by edge against outcomes derived from the first-rising-edge rules.
module tb_sim_run_ctrl;

  localparam int         N_CH  = 3;
  localparam int         TMO   = 50;
  localparam int         DRN   = 4;
  localparam int         HLD   = 3;
  localparam logic [2:0] FMASK = 3'b100;
  localparam int         CNT_W = $clog2(TMO + 1);
  localparam int         WLEN  = 64;

  logic             sysclk = 1'b0;
  logic             rst_n  = 1'b0;
  logic [2:0]       i_evt  = '0;
  logic             o_dut_rst;
  logic             o_done;
  logic [1:0]       o_status;
  logic [1:0]       o_evt_ch;
  logic [CNT_W-1:0] o_cycles;

  logic [2:0] wave [0:WLEN-1];
  int total = 0;
  int bad   = 0;

  always #5 sysclk = ~sysclk;

  sim_run_ctrl #(
    .N_CH         (N_CH),
    .TIMEOUT_CYC  (TMO),
    .DRAIN_CYC    (DRN),
    .RST_HOLD_CYC (HLD),
    .FAIL_MASK    (FMASK)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .i_evt     (i_evt),
    .o_dut_rst (o_dut_rst),
    .o_done    (o_done),
    .o_status  (o_status),
    .o_evt_ch  (o_evt_ch),
    .o_cycles  (o_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".rst.dut_rst"}, 32'(o_dut_rst), 32'd1);
    chk({name, ".rst.done"},    32'(o_done),    32'd0);
    chk({name, ".rst.status"},  32'(o_status),  32'd0);
    chk({name, ".rst.ch"},      32'(o_evt_ch),  32'd0);
    chk({name, ".rst.cycles"},  32'(o_cycles),  32'd0);
  endtask

  task automatic fill(input logic [2:0] v, input int from);
    for (int c = from; c < WLEN; c++) wave[c] = v;
  endtask

  // One run: reset, hold, then apply wave[c] during RUN cycle c (c=0 ends at
  // edge j=1 after RUN entry). abort_j>0 pulls rst_n low after edge abort_j.
  task automatic run(input string name, input logic [2:0] hold, input int abort_j);
    logic [2:0] prev, rise;
    int dec_e, done_e, st, ch, last;

    // Expected outcome: first rising edge among RUN cycles 0..TMO-1.
    dec_e = TMO; done_e = TMO; st = 3; ch = 0;
    prev = hold;
    for (int c = 0; c < TMO; c++) begin
      rise = wave[c] & ~prev;
      if (rise != 3'b000) begin
        ch     = rise[0] ? 0 : (rise[1] ? 1 : 2);
        st     = FMASK[ch] ? 2 : 1;
        dec_e  = c + 1;
        done_e = dec_e + DRN;
        break;
      end
      prev = wave[c];
    end

    rst_n = 1'b0;
    i_evt = hold;
    step();
    chk_reset(name);
    rst_n = 1'b1;
    for (int e = 0; e < HLD; e++) begin
      step();
      chk({name, ".hold.dut_rst"}, 32'(o_dut_rst), 32'd1);
    end
    step();
    chk({name, ".entry.dut_rst"}, 32'(o_dut_rst), 32'd0);
    chk({name, ".entry.status"},  32'(o_status),  32'd0);

    last = done_e + 2;
    for (int j = 1; j <= last; j++) begin
      i_evt = wave[j-1];
      step();
      chk({name, ".status"},  32'(o_status),  (j >= dec_e) ? 32'(st) : 32'd0);
      chk({name, ".ch"},      32'(o_evt_ch),  (j >= dec_e) ? 32'(ch) : 32'd0);
      chk({name, ".cycles"},  32'(o_cycles),  (j < dec_e) ? 32'(j) : 32'(dec_e));
      chk({name, ".done"},    32'(o_done),    (j >= done_e) ? 32'd1 : 32'd0);
      chk({name, ".dut_rst"}, 32'(o_dut_rst), 32'd0);
      if (j == abort_j) begin
        rst_n = 1'b0;
        step();
        chk_reset({name, ".abort"});
        $display("run %s: aborted after edge %0d", name, j);
        return;
      end
    end
    $display("run %s: status=%0d ch=%0d cycles=%0d done=%0d", name, o_status, o_evt_ch, o_cycles, o_done);
  endtask

  initial begin
    logic [2:0] cur, hold;
    int rate;

    // Pass on channel 0 at RUN cycle 10.
    fill(3'b000, 0); fill(3'b001, 10);
    run("pass", 3'b000, 0);

    // Two channels together: lowest index wins, channel 1 is not a fail channel.
    fill(3'b000, 0); fill(3'b110, 5);
    run("prio", 3'b000, 0);

    // Fail channel alone.
    fill(3'b000, 0); fill(3'b100, 7);
    run("fail", 3'b000, 0);

    // Nothing happens.
    fill(3'b000, 0);
    run("timeout", 3'b000, 0);

    // Edge in the very last RUN cycle beats the timeout.
    fill(3'b000, 0); fill(3'b001, TMO - 1);
    run("late_evt", 3'b000, 0);

    // Level already high through HOLD is not an event.
    fill(3'b010, 0);
    run("level_hi", 3'b010, 0);

    // Edge on a fail channel during DRAIN is ignored.
    fill(3'b000, 0); fill(3'b001, 3); fill(3'b101, 5);
    run("drain_ign", 3'b000, 0);

    // Reset while draining, then a clean repeat.
    fill(3'b000, 0); fill(3'b001, 2);
    run("abort", 3'b000, 5);
    fill(3'b000, 0); fill(3'b001, 10);
    run("after_abort", 3'b000, 0);

    for (int k = 0; k < 20; k++) begin
      hold = 3'($urandom_range(0, 7));
      rate = $urandom_range(4, 120);
      cur  = hold;
      for (int c = 0; c < WLEN; c++) begin
        for (int b = 0; b < 3; b++) begin
          if ($urandom_range(0, rate) == 0) cur[b] = ~cur[b];
        end
        wave[c] = cur;
      end
      run($sformatf("rnd%0d", k), hold, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
